fft_stage_ctrl: RTL
===================

Name: fft_stage_ctrl

Overview:
Sequencer for the in-place radix-2 DIT FFT over the ping-pong memory banks. After the bit-reversed sample set has been written into bank 0, a start pulse makes this block step through all LOG2N stages. Per stage it issues N/2 butterfly read address pairs and twiddle indices, then replays the matching write addresses after the butterfly latency. It alternates read/write banks per stage and flags completion plus the bank holding the result.

Parameters:
N, 8, transform length; power of two, >= 4
LOG2N, 3, log2(N); address width
BFLY_LAT, 2, butterfly datapath latency in cycles from rd_en to the matching wr_en; >= 1

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request; accepted only in IDLE
busy  out  1  high from the cycle after accepted start through the final write
done  out  1  one-cycle pulse, the cycle after the final write
rd_en  out  1  butterfly read strobe
rd_bank  out  1  bank read this stage
rd_addr_a  out  LOG2N  upper butterfly input address
rd_addr_b  out  LOG2N  lower butterfly input address
tw_addr  out  LOG2N-1  twiddle ROM index, aligned with rd_en
wr_en  out  1  write strobe, rd_en delayed exactly BFLY_LAT cycles
wr_bank  out  1  bank written (= rd_bank of the same butterfly, inverted)
wr_addr_a  out  LOG2N  rd_addr_a delayed BFLY_LAT cycles
wr_addr_b  out  LOG2N  rd_addr_b delayed BFLY_LAT cycles
stage  out  LOG2N  current read stage index 0..LOG2N-1
result_bank  out  1  bank holding final output; valid when done is high and held until next start

Behaviour:
- Reset (async assert, sync release): state IDLE; every output 0; delay pipeline cleared.
- States: IDLE -> RUN on start. RUN issues N/2 reads (j = 0..N/2-1, one per cycle), then -> DRAIN. DRAIN holds rd_en low for BFLY_LAT cycles. At DRAIN exit: if stage < LOG2N-1, increment stage and -> RUN; else -> FINISH. FINISH: done=1 for one cycle, busy=0, then -> IDLE.
- Address generation, stage s, butterfly j: span = 1<<s; a = ((j>>s) << (s+1)) | (j & (span-1)); b = a + span; tw = (j & (span-1)) << (LOG2N-1-s). All arithmetic is unsigned and truncated to the port width.
- Bank: rd_bank = s[0], wr_bank = ~s[0]. result_bank = LOG2N[0] is latched when FINISH is entered.
- The write pipeline is a BFLY_LAT-deep shift register of {en, bank, a, b}. It keeps shifting in DRAIN and FINISH, so the last write of stage s lands in the final DRAIN cycle. The first read of stage s+1 occurs the cycle after that write.
- Timing: accepted start at cycle 0 -> first rd_en at cycle 1. Total busy cycles = LOG2N*(N/2+BFLY_LAT). With N=8 and BFLY_LAT=2, busy spans cycles 1..18 and done is at cycle 19.
- start while busy, or in the FINISH cycle: ignored, with no effect on the sequence.
- rd_en and wr_en are never simultaneously high for the same address within a stage. Cross-stage overlap is impossible because of DRAIN.
- Reset mid-operation: immediate abort to IDLE. Pending writes are discarded (wr_en = 0), and done is not pulsed.
- When rd_en/wr_en are low, address outputs hold their last value; they are don't-care for the bench.

Decomposition:
- fft_pkg: N, LOG2N, BFLY_LAT defaults; the state enum {IDLE, RUN, DRAIN, FINISH}; a function computing span masks.
- One sub-module, fft_bfly_addr_gen. It is purely combinational: (stage, j) -> (a, b, tw). It is instantiated once; the delay pipeline and FSM stay in fft_stage_ctrl.

Test Plan:
- N=8, BFLY_LAT=2, start at cycle 0 -> stage 0 reads (0,1),(2,3),(4,5),(6,7) with tw 0,0,0,0 on cycles 1-4, rd_bank=0. Writes of the same pairs on cycles 3-6 with wr_bank=1.
- Same run, stage 1 -> reads (0,2)tw0,(1,3)tw2,(4,6)tw0,(5,7)tw2 on cycles 7-10 with rd_bank=1. Stage 2 -> (0,4)tw0,(1,5)tw1,(2,6)tw2,(3,7)tw3 on cycles 13-16 with rd_bank=0.
- Same run -> last wr_en at cycle 18, done=1 only at cycle 19 with result_bank=1, busy low from cycle 19. A scoreboard checks wr_en equals rd_en delayed exactly 2 cycles throughout.
- start pulsed again at cycles 5 and 19 during a run -> sequence unchanged, no extra done pulse. A start at cycle 21 runs a clean second transform.
- rst_n asserted at cycle 9 -> all outputs 0 asynchronously, no further wr_en, no done. A new start after release -> full correct sequence from stage 0.
- N=16, LOG2N=4, BFLY_LAT=1 -> 4 stages of 8 reads, busy for 36 cycles, result_bank=0. Stage 3 pair j=5 is (5,13) with tw=5.

Source files
------------

// File: rtl/fft_pkg.sv
// fft_pkg: shared defaults, FSM state type and address helper for the FFT
// stage sequencer.
//   FFT_N / FFT_LOG2N / FFT_BFLY_LAT : default transform length, address
//                                      width and butterfly latency
//   fsm_state_t                      : sequencer states
//   span_mask(s)                     : (1 << s) - 1, low-bit mask of a stage span
package fft_pkg;

   localparam int FFT_N        = 8;
   localparam int FFT_LOG2N    = 3;
   localparam int FFT_BFLY_LAT = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      DRAIN  = 2'd2,
      FINISH = 2'd3
   } fsm_state_t;

   function automatic int unsigned span_mask(input int unsigned s);
      return (32'd1 << s) - 32'd1;
   endfunction

endpackage

// File: rtl/fft_bfly_addr_gen.sv
// fft_bfly_addr_gen: combinational radix-2 DIT butterfly address generator.
//   stage   in  LOG2N    stage index s
//   j       in  LOG2N-1  butterfly index within the stage
//   addr_a  out LOG2N    upper input address
//   addr_b  out LOG2N    lower input address (addr_a + span)
//   tw_addr out LOG2N-1  twiddle ROM index
module fft_bfly_addr_gen
   import fft_pkg::*;
#(
   parameter int LOG2N = FFT_LOG2N
) (
   input  logic [LOG2N-1:0] stage,
   input  logic [LOG2N-2:0] j,
   output logic [LOG2N-1:0] addr_a,
   output logic [LOG2N-1:0] addr_b,
   output logic [LOG2N-2:0] tw_addr
);

   localparam int unsigned AW   = LOG2N;
   localparam int unsigned TW_W = LOG2N - 1;

   int unsigned s_i;
   int unsigned j_i;
   int unsigned span_i;
   int unsigned mask_i;
   int unsigned a_i;
   int unsigned tw_i;

   always_comb begin
      s_i    = 32'(stage);
      j_i    = 32'(j);
      span_i = 32'd1 << s_i;
      mask_i = span_mask(s_i);
      // Insert a zero at bit position s of j: groups of 'span' butterflies
      // are spaced 2*span apart.
      a_i    = ((j_i >> s_i) << (s_i + 32'd1)) | (j_i & mask_i);
      tw_i   = (j_i & mask_i) << (AW - 32'd1 - s_i);
      addr_a  = AW'(a_i);
      addr_b  = AW'(a_i + span_i);
      tw_addr = TW_W'(tw_i);
   end

endmodule

// File: rtl/fft_stage_ctrl.sv
// fft_stage_ctrl: in-place radix-2 DIT FFT stage sequencer over ping-pong banks.
//   clk, rst_n      clock / async active-low reset
//   start           one-cycle request, accepted only in IDLE
//   busy, done      run indicator / one-cycle completion pulse
//   rd_en, rd_bank, rd_addr_a, rd_addr_b, tw_addr   butterfly read side
//   wr_en, wr_bank, wr_addr_a, wr_addr_b            write side, BFLY_LAT later
//   stage           current read stage
//   result_bank     bank holding the final output
//
// state  | meaning
// IDLE   | waiting for start
// RUN    | one butterfly read per cycle, j = 0..N/2-1
// DRAIN  | BFLY_LAT cycles with no reads while the write pipe empties
// FINISH | done pulse, back to IDLE
module fft_stage_ctrl
   import fft_pkg::*;
#(
   parameter int N        = FFT_N,
   parameter int LOG2N    = FFT_LOG2N,
   parameter int BFLY_LAT = FFT_BFLY_LAT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             rd_en,
   output logic             rd_bank,
   output logic [LOG2N-1:0] rd_addr_a,
   output logic [LOG2N-1:0] rd_addr_b,
   output logic [LOG2N-2:0] tw_addr,
   output logic             wr_en,
   output logic             wr_bank,
   output logic [LOG2N-1:0] wr_addr_a,
   output logic [LOG2N-1:0] wr_addr_b,
   output logic [LOG2N-1:0] stage,
   output logic             result_bank
);

   localparam int J_W   = LOG2N - 1;
   localparam int TMR_W = (BFLY_LAT < 2) ? 1 : $clog2(BFLY_LAT);

   localparam logic [J_W-1:0]   J_LAST     = J_W'(N / 2 - 1);
   localparam logic [LOG2N-1:0] STAGE_LAST = LOG2N'(LOG2N - 1);
   localparam logic [TMR_W-1:0] TMR_LOAD   = TMR_W'(BFLY_LAT - 1);
   localparam logic             RES_BANK   = 1'(LOG2N % 2);

   fsm_state_t state_q, state_d;

   logic [J_W-1:0]   j_q;
   logic [LOG2N-1:0] stage_q;
   logic [TMR_W-1:0] tmr_q;
   logic             result_bank_q;

   logic j_last, drain_end, stage_last;

   logic [LOG2N-1:0] gen_a, gen_b;
   logic [LOG2N-2:0] gen_tw;
   logic [LOG2N-1:0] hold_a, hold_b;
   logic [LOG2N-2:0] hold_tw;

   logic             pipe_en   [BFLY_LAT];
   logic             pipe_bank [BFLY_LAT];
   logic [LOG2N-1:0] pipe_a    [BFLY_LAT];
   logic [LOG2N-1:0] pipe_b    [BFLY_LAT];

   assign j_last     = (j_q == J_LAST);
   assign drain_end  = (tmr_q == '0);
   assign stage_last = (stage_q == STAGE_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (j_last) state_d = DRAIN;
         DRAIN:   if (drain_end) state_d = stage_last ? FINISH : RUN;
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      rd_en = 1'b0;
      busy  = 1'b0;
      done  = 1'b0;
      unique case (state_q)
         RUN:     begin rd_en = 1'b1; busy = 1'b1; end
         DRAIN:   busy = 1'b1;
         FINISH:  done = 1'b1;
         default: ;
      endcase
   end

   // Butterfly index, stage index and drain timer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         j_q           <= '0;
         stage_q       <= '0;
         tmr_q         <= '0;
         result_bank_q <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  stage_q <= '0;
                  j_q     <= '0;
               end
            end
            RUN: begin
               j_q <= j_q + J_W'(1);
               if (j_last) tmr_q <= TMR_LOAD;
            end
            DRAIN: begin
               if (!drain_end) begin
                  tmr_q <= tmr_q - TMR_W'(1);
               end else if (stage_last) begin
                  result_bank_q <= RES_BANK;
               end else begin
                  stage_q <= stage_q + LOG2N'(1);
                  j_q     <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   fft_bfly_addr_gen #(.LOG2N(LOG2N)) u_addr_gen (
      .stage   (stage_q),
      .j       (j_q),
      .addr_a  (gen_a),
      .addr_b  (gen_b),
      .tw_addr (gen_tw)
   );

   // Read-side addresses hold their last issued value between reads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_a  <= '0;
         hold_b  <= '0;
         hold_tw <= '0;
      end else if (rd_en) begin
         hold_a  <= gen_a;
         hold_b  <= gen_b;
         hold_tw <= gen_tw;
      end
   end

   assign rd_addr_a   = rd_en ? gen_a  : hold_a;
   assign rd_addr_b   = rd_en ? gen_b  : hold_b;
   assign tw_addr     = rd_en ? gen_tw : hold_tw;
   assign rd_bank     = stage_q[0];
   assign stage       = stage_q;
   assign result_bank = result_bank_q;

   // Write replay pipe; shifts every cycle so the tail of a stage drains
   // during DRAIN and FINISH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BFLY_LAT; i++) begin
            pipe_en[i]   <= 1'b0;
            pipe_bank[i] <= 1'b0;
            pipe_a[i]    <= '0;
            pipe_b[i]    <= '0;
         end
      end else begin
         pipe_en[0]   <= rd_en;
         pipe_bank[0] <= ~rd_bank;
         pipe_a[0]    <= rd_addr_a;
         pipe_b[0]    <= rd_addr_b;
         for (int i = 1; i < BFLY_LAT; i++) begin
            pipe_en[i]   <= pipe_en[i-1];
            pipe_bank[i] <= pipe_bank[i-1];
            pipe_a[i]    <= pipe_a[i-1];
            pipe_b[i]    <= pipe_b[i-1];
         end
      end
   end

   assign wr_en     = pipe_en[BFLY_LAT-1];
   assign wr_bank   = pipe_bank[BFLY_LAT-1];
   assign wr_addr_a = pipe_a[BFLY_LAT-1];
   assign wr_addr_b = pipe_b[BFLY_LAT-1];

endmodule
